// File: rtl/note_player.sv
// Note player: buffers 8-bit note codes in a FIFO and plays each one as a square wave.
// Every note lasts a fixed number of cycles and may be followed by a silent gap.
module note_player #(
  parameter int unsigned CLK_HZ      = 100_000_000,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned NOTE_CYCLES = 25_000_000,
  parameter int unsigned GAP_CYCLES  = 1_000_000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic [7:0]               note_in,
  input  logic                     note_valid,
  output logic                     note_ready,
  input  logic                     play_en,
  output logic                     tone_out,
  output logic                     playing,
  output logic [7:0]               note_now,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     done
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  // Octave-0 half-period in clock cycles, rounded to the nearest cycle.
  function automatic int unsigned half0(input int unsigned semi);
    real hz;
    hz = 440.0 * (2.0 ** ((real'(semi) - 9.0) / 12.0 - 4.0));
    return $rtoi(real'(CLK_HZ) / (2.0 * hz) + 0.5);
  endfunction

  localparam int unsigned HALF_C0 = half0(0);
  localparam int unsigned HW      = (HALF_C0 > 1) ? $clog2(HALF_C0 + 1) : 1;
  typedef logic [HW-1:0] half_t;

  localparam half_t HALF0 [12] = '{
    half_t'(half0(0)), half_t'(half0(1)), half_t'(half0(2)),  half_t'(half0(3)),
    half_t'(half0(4)), half_t'(half0(5)), half_t'(half0(6)),  half_t'(half0(7)),
    half_t'(half0(8)), half_t'(half0(9)), half_t'(half0(10)), half_t'(half0(11))
  };

  localparam int unsigned DUR_MAX = (NOTE_CYCLES >= GAP_CYCLES) ? NOTE_CYCLES : GAP_CYCLES;
  localparam int unsigned DW      = (DUR_MAX > 1) ? $clog2(DUR_MAX) : 1;
  localparam logic [DW-1:0] NOTE_LAST = DW'(NOTE_CYCLES - 1);
  localparam logic [DW-1:0] GAP_LAST  = (GAP_CYCLES > 0) ? DW'(GAP_CYCLES - 1) : '0;

  typedef enum logic [1:0] {IDLE, LOAD, PLAY, GAP} state_t;

  state_t          state_q, state_d;
  logic [7:0]      mem_q [DEPTH];
  logic [AW-1:0]   wptr_q, rptr_q;
  logic [CW-1:0]   count_q;
  logic [7:0]      note_now_q, note_now_d;
  half_t           half_q, half_d;
  half_t           hcnt_q, hcnt_d;
  logic            rest_q, rest_d;
  logic [DW-1:0]   dur_q, dur_d;
  logic            tone_q, tone_d;
  logic            done_q, done_d;
  logic            push, pop, exiting, can_start;

  logic [3:0]      octave, semitone;
  logic            lookup_rest;
  half_t           base_half, shifted_half, lookup_half;

  assign note_ready = (count_q < CW'(DEPTH));
  assign push       = note_valid && note_ready && !clear;
  assign can_start  = play_en && (count_q != '0);

  // Table lookup for the note held in note_now; codes outside the scale are rests.
  assign octave       = note_now_q[7:4];
  assign semitone     = note_now_q[3:0];
  assign lookup_rest  = (note_now_q == 8'hFF) || (octave > 4'd8) || (semitone > 4'd11);
  assign base_half    = HALF0[(semitone > 4'd11) ? 4'd0 : semitone];
  assign shifted_half = base_half >> octave;
  assign lookup_half  = (shifted_half == '0) ? half_t'(1) : shifted_half;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= note_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (clear) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wptr_q <= wptr_q + 1'b1;
      end
      if (pop) begin
        rptr_q <= rptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    note_now_d = note_now_q;
    half_d     = half_q;
    hcnt_d     = hcnt_q;
    rest_d     = rest_q;
    dur_d      = dur_q;
    tone_d     = tone_q;
    done_d     = 1'b0;
    pop        = 1'b0;
    exiting    = 1'b0;

    case (state_q)
      IDLE: begin
        if (can_start) begin
          state_d = LOAD;
          pop     = 1'b1;
        end
      end
      LOAD: begin
        half_d  = lookup_half;
        rest_d  = lookup_rest;
        hcnt_d  = '0;
        dur_d   = '0;
        tone_d  = 1'b0;
        state_d = PLAY;
      end
      PLAY: begin
        if (!rest_q) begin
          if (hcnt_q == half_q - 1'b1) begin
            hcnt_d = '0;
            tone_d = ~tone_q;
          end else begin
            hcnt_d = hcnt_q + 1'b1;
          end
        end
        if (dur_q == NOTE_LAST) begin
          dur_d  = '0;
          tone_d = 1'b0;
          if (GAP_CYCLES > 0) begin
            state_d = GAP;
          end else begin
            exiting = 1'b1;
          end
        end else begin
          dur_d = dur_q + 1'b1;
        end
      end
      GAP: begin
        if (dur_q == GAP_LAST) begin
          dur_d   = '0;
          exiting = 1'b1;
        end else begin
          dur_d = dur_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // The end of a note chains straight into the next one when allowed.
    if (exiting) begin
      if (can_start) begin
        state_d = LOAD;
        pop     = 1'b1;
      end else begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    end

    if (pop) begin
      note_now_d = mem_q[rptr_q];
    end

    if (clear) begin
      state_d    = IDLE;
      pop        = 1'b0;
      done_d     = 1'b0;
      tone_d     = 1'b0;
      note_now_d = note_now_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      note_now_q <= 8'hFF;
      half_q     <= '0;
      hcnt_q     <= '0;
      rest_q     <= 1'b1;
      dur_q      <= '0;
      tone_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      note_now_q <= note_now_d;
      half_q     <= half_d;
      hcnt_q     <= hcnt_d;
      rest_q     <= rest_d;
      dur_q      <= dur_d;
      tone_q     <= tone_d;
      done_q     <= done_d;
    end
  end

  assign tone_out   = tone_q && (state_q == PLAY);
  assign playing    = (state_q != IDLE);
  assign note_now   = note_now_q;
  assign fifo_count = count_q;
  assign done       = done_q;

endmodule

// File: tb/tb_note_player.sv
// Self-checking bench for note_player: scaled-down clock so whole notes fit in a short run,
// with the expected waveform computed from the note-to-frequency rule.
module tb_note_player;

  localparam int unsigned CLK_HZ      = 100_000;
  localparam int unsigned DEPTH       = 16;
  localparam int unsigned NOTE_CYCLES = 400;
  localparam int unsigned GAP_CYCLES  = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       clear = 1'b0;
  logic [7:0] note_in = 8'h00;
  logic       note_valid = 1'b0;
  logic       play_en = 1'b0;
  logic       note_ready, tone_out, playing, done;
  logic [7:0] note_now;
  logic [4:0] fifo_count;

  int nCompared = 0;
  int nMismatched = 0;
  logic [7:0] fifoModel[$];

  note_player #(
    .CLK_HZ(CLK_HZ), .DEPTH(DEPTH), .NOTE_CYCLES(NOTE_CYCLES), .GAP_CYCLES(GAP_CYCLES)
  ) dut (
    .clk(clk), .reset(reset), .clear(clear), .note_in(note_in), .note_valid(note_valid),
    .note_ready(note_ready), .play_en(play_en), .tone_out(tone_out), .playing(playing),
    .note_now(note_now), .fifo_count(fifo_count), .done(done)
  );

  always #5 clk = ~clk;

  // Expected half-period straight from the musical definition; 0 marks a rest.
  function automatic int expHalf(input logic [7:0] code);
    int oct, semi, h0;
    real hz;
    oct  = int'(code[7:4]);
    semi = int'(code[3:0]);
    if (code == 8'hFF || oct > 8 || semi > 11) return 0;
    hz = 440.0 * (2.0 ** ((real'(semi) - 9.0) / 12.0 - 4.0));
    h0 = int'(real'(CLK_HZ) / (2.0 * hz));
    return h0 >> oct;
  endfunction

  function automatic logic [7:0] randCode();
    int r;
    logic [3:0] o, s;
    r = int'($urandom_range(0, 9));
    if (r == 0) return 8'hFF;
    if (r == 1) begin
      o = 4'($urandom_range(9, 15));
      s = 4'($urandom_range(0, 15));
      return {o, s};
    end
    o = 4'($urandom_range(3, 8));
    s = 4'($urandom_range(0, 11));
    return {o, s};
  endfunction

  task automatic stepClk();
    @(posedge clk);
    #1;
  endtask

  task automatic pushNote(input logic [7:0] code);
    logic expReady;
    expReady = (fifoModel.size() < DEPTH);
    nCompared++;
    if (note_ready !== expReady) begin
      nMismatched++;
      $display("[TB] FAIL push_ready: note_ready=%b expected %b", note_ready, expReady);
    end
    note_in = code;
    note_valid = 1'b1;
    stepClk();
    note_valid = 1'b0;
    if (expReady) fifoModel.push_back(code);
  endtask

  // Walks one or more notes starting from a LOAD-cycle sample, following the exit rule.
  task automatic runPlayback(input logic [7:0] first, input int dropAt,
                             input bit hasPending, input logic [7:0] pendingCode);
    logic [7:0] cur;
    int h, bad, firstBad, expTone, drop;
    cur = first;
    drop = dropAt;
    while (1) begin
      nCompared++;
      if (playing !== 1'b1 || note_now !== cur || tone_out !== 1'b0 || done !== 1'b0 ||
          fifo_count !== 5'(fifoModel.size())) begin
        nMismatched++;
        $display("[TB] FAIL load: playing=%b note_now=%h tone=%b done=%b count=%0d, expected 1 %h 0 0 %0d",
                 playing, note_now, tone_out, done, fifo_count, cur, fifoModel.size());
      end
      if (hasPending) begin
        fifoModel.push_back(pendingCode);
        hasPending = 1'b0;
      end
      h = expHalf(cur);
      bad = 0;
      firstBad = -1;
      for (int k = 0; k < int'(NOTE_CYCLES); k++) begin
        stepClk();
        note_valid = 1'b0;
        if (k == drop) play_en = 1'b0;
        expTone = (h == 0) ? 0 : ((k / h) % 2);
        if (tone_out !== 1'(expTone) || playing !== 1'b1 || note_now !== cur || done !== 1'b0) begin
          if (firstBad < 0) firstBad = k;
          bad++;
        end
      end
      drop = -1;
      nCompared++;
      if (bad != 0) begin
        nMismatched++;
        $display("[TB] FAIL play_tone: note %h had %0d bad cycles (first at %0d, half %0d), expected 0",
                 cur, bad, firstBad, h);
      end
      bad = 0;
      for (int g = 0; g < int'(GAP_CYCLES); g++) begin
        stepClk();
        if (tone_out !== 1'b0 || playing !== 1'b1 || done !== 1'b0) bad++;
      end
      nCompared++;
      if (bad != 0) begin
        nMismatched++;
        $display("[TB] FAIL gap: note %h had %0d bad gap cycles, expected 0", cur, bad);
      end
      stepClk();
      if (play_en && fifoModel.size() > 0) begin
        cur = fifoModel.pop_front();
      end else begin
        nCompared++;
        if (playing !== 1'b0 || done !== 1'b1) begin
          nMismatched++;
          $display("[TB] FAIL done_pulse: playing=%b done=%b expected 0 1", playing, done);
        end
        stepClk();
        nCompared++;
        if (playing !== 1'b0 || done !== 1'b0) begin
          nMismatched++;
          $display("[TB] FAIL done_single: playing=%b done=%b expected 0 0", playing, done);
        end
        break;
      end
    end
  endtask

  task automatic startPlayback(input int dropAt);
    logic [7:0] cur;
    play_en = 1'b1;
    stepClk();
    cur = fifoModel.pop_front();
    runPlayback(cur, dropAt, 1'b0, 8'h00);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    stepClk();
    stepClk();
    nCompared++;
    if (fifo_count !== 5'd0 || note_ready !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL reset_fifo: count=%0d ready=%b expected 0 1", fifo_count, note_ready);
    end
    nCompared++;
    if (tone_out !== 1'b0 || playing !== 1'b0 || done !== 1'b0 || note_now !== 8'hFF) begin
      nMismatched++;
      $display("[TB] FAIL reset_out: tone=%b playing=%b done=%b note_now=%h expected 0 0 0 ff",
               tone_out, playing, done, note_now);
    end
    reset = 1'b0;
    stepClk();
  endtask

  task automatic test_single_note();
    logic [7:0] cur;
    play_en = 1'b1;
    note_in = 8'h49;
    note_valid = 1'b1;
    stepClk();
    note_valid = 1'b0;
    fifoModel.push_back(8'h49);
    nCompared++;
    if (playing !== 1'b0 || fifo_count !== 5'd1) begin
      nMismatched++;
      $display("[TB] FAIL latency_push: playing=%b count=%0d expected 0 1", playing, fifo_count);
    end
    stepClk();
    cur = fifoModel.pop_front();
    runPlayback(cur, -1, 1'b0, 8'h00);
  endtask

  task automatic test_rest_and_gap();
    play_en = 1'b0;
    pushNote(8'h49);
    pushNote(8'hFF);
    pushNote(8'h4C);
    startPlayback(-1);
  endtask

  task automatic test_invalid_codes();
    play_en = 1'b0;
    pushNote(8'h9C);
    pushNote(8'h3D);
    startPlayback(-1);
  endtask

  task automatic test_full_random();
    logic [7:0] extra, cur;
    play_en = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) pushNote(randCode());
    extra = randCode();
    note_in = extra;
    note_valid = 1'b1;
    stepClk();
    stepClk();
    stepClk();
    nCompared++;
    if (fifo_count !== 5'd16 || note_ready !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL full_hold: count=%0d ready=%b expected 16 0", fifo_count, note_ready);
    end
    play_en = 1'b1;
    stepClk();
    cur = fifoModel.pop_front();
    nCompared++;
    if (note_ready !== 1'b1 || fifo_count !== 5'd15) begin
      nMismatched++;
      $display("[TB] FAIL full_release: ready=%b count=%0d expected 1 15", note_ready, fifo_count);
    end
    runPlayback(cur, -1, 1'b1, extra);
  endtask

  task automatic test_back_to_back();
    logic [7:0] extra, cur;
    play_en = 1'b0;
    for (int i = 0; i < 5; i++) pushNote(randCode());
    extra = randCode();
    note_in = extra;
    note_valid = 1'b1;
    play_en = 1'b1;
    stepClk();
    note_valid = 1'b0;
    cur = fifoModel.pop_front();
    fifoModel.push_back(extra);
    nCompared++;
    if (fifo_count !== 5'd5) begin
      nMismatched++;
      $display("[TB] FAIL push_pop_count: count=%0d expected 5", fifo_count);
    end
    runPlayback(cur, -1, 1'b0, 8'h00);
  endtask

  task automatic test_play_en_drop();
    play_en = 1'b0;
    pushNote(8'h45);
    pushNote(8'h52);
    startPlayback(200);
    nCompared++;
    if (fifo_count !== 5'd1 || playing !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL drop_hold: count=%0d playing=%b expected 1 0", fifo_count, playing);
    end
    startPlayback(-1);
  endtask

  task automatic test_clear();
    play_en = 1'b0;
    pushNote(8'h49);
    pushNote(8'h4C);
    pushNote(8'h57);
    pushNote(8'h60);
    play_en = 1'b1;
    stepClk();
    void'(fifoModel.pop_front());
    for (int k = 0; k < 200; k++) stepClk();
    nCompared++;
    if (tone_out !== 1'(((199 / expHalf(8'h49)) % 2))) begin
      nMismatched++;
      $display("[TB] FAIL clear_pre_tone: tone=%b expected %0d", tone_out, (199 / expHalf(8'h49)) % 2);
    end
    clear = 1'b1;
    stepClk();
    clear = 1'b0;
    fifoModel.delete();
    nCompared++;
    if (fifo_count !== 5'd0 || tone_out !== 1'b0 || playing !== 1'b0 || done !== 1'b0 ||
        note_now !== 8'h49 || note_ready !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL clear: count=%0d tone=%b playing=%b done=%b note_now=%h ready=%b expected 0 0 0 0 49 1",
               fifo_count, tone_out, playing, done, note_now, note_ready);
    end
    for (int k = 0; k < 5; k++) stepClk();
    nCompared++;
    if (playing !== 1'b0 || done !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL clear_idle: playing=%b done=%b expected 0 0", playing, done);
    end
  endtask

  task automatic test_async_reset();
    play_en = 1'b0;
    pushNote(8'h49);
    pushNote(8'h4C);
    play_en = 1'b1;
    stepClk();
    for (int k = 0; k < 150; k++) stepClk();
    #2;
    reset = 1'b1;
    #1;
    nCompared++;
    if (tone_out !== 1'b0 || playing !== 1'b0 || done !== 1'b0 || note_now !== 8'hFF ||
        fifo_count !== 5'd0 || note_ready !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL async_reset: tone=%b playing=%b done=%b note_now=%h count=%0d ready=%b expected 0 0 0 ff 0 1",
               tone_out, playing, done, note_now, fifo_count, note_ready);
    end
    fifoModel.delete();
    stepClk();
    reset = 1'b0;
    stepClk();
    stepClk();
    nCompared++;
    if (playing !== 1'b0 || fifo_count !== 5'd0) begin
      nMismatched++;
      $display("[TB] FAIL post_reset_idle: playing=%b count=%0d expected 0 0", playing, fifo_count);
    end
  endtask

  initial begin
    test_reset();
    test_single_note();
    test_rest_and_gap();
    test_invalid_codes();
    test_full_random();
    test_back_to_back();
    test_play_en_drop();
    test_clear();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
